// File: rtl/i2c_bus_clear_detect_if.sv
// Pin-side bundle for the I2C bus-clear detector: raw pins and enable in, filtered levels and strobes out.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a plain level or a single-cycle strobe.
// Ports: enable_i, scl_i, sda_i (to detector); scl_o, sda_o, start_o, stop_o, armed_o, bus_reset_o (from detector).
interface i2c_bus_clear_detect_if;
    logic enable_i;
    logic scl_i;
    logic sda_i;
    logic scl_o;
    logic sda_o;
    logic start_o;
    logic stop_o;
    logic armed_o;
    logic bus_reset_o;

    // Detector side.
    modport slave (
        input  enable_i, scl_i, sda_i,
        output scl_o, sda_o, start_o, stop_o, armed_o, bus_reset_o
    );

    // Pad / controller side.
    modport master (
        output enable_i, scl_i, sda_i,
        input  scl_o, sda_o, start_o, stop_o, armed_o, bus_reset_o
    );
endinterface

// File: rtl/i2c_bus_clear_detect.sv
// I2C bus-clear detector: filters SCL/SDA and pulses bus_reset_o after >=MIN_PULSES clean SCL rises and a START/STOP.
// Latency: pin to filtered level 2+FILT cycles; strobes one cycle after the filtered edge; bus_reset_o one cycle after the strobe.
// Backpressure: none; inputs are sampled every cycle and the reset pulse always runs RST_LEN cycles.
// Ports: clk_i, rst_ni (sync, active low); bus.slave carries enable_i, scl_i, sda_i in and
//        scl_o, sda_o, start_o, stop_o, armed_o, bus_reset_o out.
module i2c_bus_clear_detect #(
    parameter int unsigned FILT       = 3,
    parameter int unsigned MIN_PULSES = 9,
    parameter int unsigned RST_LEN    = 63
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    i2c_bus_clear_detect_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COUNT, ARMED, RESET} state_t;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d;
    logic [1:0]      filt_p_q;
    logic [1:0][3:0] fcnt_q, fcnt_d;

    logic       start_q, stop_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rcnt_q, rcnt_d;

    logic scl_p, scl_c, sda_p, sda_c;
    logic rise, start_ev, stop_ev, brk_ev;
    logic [3:0] cnt_inc;

    // Glitch filter: the level only moves after FILT consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == 4'(FILT - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign scl_p = filt_p_q[0];
    assign scl_c = filt_q[0];
    assign sda_p = filt_p_q[1];
    assign sda_c = filt_q[1];

    // Requiring SCL high on both samples rejects SDA moving in the same cycle as SCL.
    assign rise     = !scl_p && scl_c;
    assign start_ev =  sda_p && !sda_c && scl_p && scl_c;
    assign stop_ev  = !sda_p &&  sda_c && scl_p && scl_c;

    // The FSM reacts to the registered strobes so bus_reset_o trails start_o/stop_o by one cycle.
    assign brk_ev  = start_q || stop_q;
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (brk_ev) cnt_d = '0;
                if (rise && sda_c) begin
                    cnt_d   = 4'd1;
                    state_d = (MIN_PULSES == 1) ? ARMED : COUNT;
                end else if (rise) begin
                    cnt_d = '0;
                end
            end
            COUNT: begin
                if (brk_ev || (rise && !sda_c)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (rise) cnt_d = cnt_inc;
                    if (cnt_q >= 4'(MIN_PULSES)) state_d = ARMED;
                end
            end
            ARMED: begin
                if (brk_ev) begin
                    state_d = RESET;
                    cnt_d   = '0;
                    rcnt_d  = 8'(RST_LEN - 1);
                end else if (rise && !sda_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    cnt_d = cnt_inc;
                end
            end
            RESET: begin
                // Bus activity is deliberately ignored until the pulse completes.
                cnt_d = '0;
                if (rcnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Disabling aborts a sequence but never shortens a pulse already issued.
        if (!bus.enable_i && state_q != RESET) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filt_q   <= 2'b11;
            filt_p_q <= 2'b11;
            fcnt_q   <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            rcnt_q   <= '0;
        end else begin
            sync1_q  <= {bus.sda_i, bus.scl_i};
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            filt_p_q <= filt_q;
            fcnt_q   <= fcnt_d;
            start_q  <= start_ev;
            stop_q   <= stop_ev;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign bus.scl_o       = filt_q[0];
    assign bus.sda_o       = filt_q[1];
    assign bus.start_o     = start_q;
    assign bus.stop_o      = stop_q;
    assign bus.armed_o     = (state_q == ARMED);
    assign bus.bus_reset_o = (state_q == RESET);

endmodule

// File: tb/tb_i2c_bus_clear_detect.sv
module tb_i2c_bus_clear_detect;
    localparam int FILT = 3;
    localparam int MINP = 9;
    localparam int RLEN = 63;

    logic clk = 1'b0;
    logic rst_n;

    i2c_bus_clear_detect_if bus_if ();

    i2c_bus_clear_detect #(
        .FILT       (FILT),
        .MIN_PULSES (MINP),
        .RST_LEN    (RLEN)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event counters maintained by the monitor; the stimulus reads deltas.
    int n_start = 0, n_stop = 0, n_rst = 0, n_rst_rise = 0, n_rise_ok = 0, n_armed = 0, n_sda_low = 0;
    int b_start, b_stop, b_rst, b_rst_rise, b_rise_ok, b_armed, b_sda_low;
    logic prev_rst  = 1'b0;
    logic prev_strb = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus_if.start_o === 1'b1) n_start++;
        if (bus_if.stop_o === 1'b1) n_stop++;
        if (bus_if.armed_o === 1'b1) n_armed++;
        if (bus_if.sda_o === 1'b0) n_sda_low++;
        if (bus_if.bus_reset_o === 1'b1) begin
            n_rst++;
            if (!prev_rst) begin
                n_rst_rise++;
                if (prev_strb) n_rise_ok++;
            end
        end
        prev_rst  = (bus_if.bus_reset_o === 1'b1);
        prev_strb = (bus_if.start_o === 1'b1) || (bus_if.stop_o === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_start = n_start; b_stop = n_stop; b_rst = n_rst; b_rst_rise = n_rst_rise;
        b_rise_ok = n_rise_ok; b_armed = n_armed; b_sda_low = n_sda_low;
    endtask

    // One SCL pulse with SDA held high: 4 cycles low, 4 cycles high.
    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            bus_if.scl_i = 1'b0; tick(4);
            bus_if.scl_i = 1'b1; tick(4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus_if.enable_i = 1'b1;
        bus_if.scl_i = 1'b1;
        bus_if.sda_i = 1'b1;
        tick(3);
        chk("rst_scl_o", bus_if.scl_o, 1);
        chk("rst_sda_o", bus_if.sda_o, 1);
        chk("rst_start_o", bus_if.start_o, 0);
        chk("rst_stop_o", bus_if.stop_o, 0);
        chk("rst_armed_o", bus_if.armed_o, 0);
        chk("rst_bus_reset_o", bus_if.bus_reset_o, 0);
        rst_n = 1'b1;
        tick(10);

        // Two-cycle SDA glitch is shorter than the filter window.
        snap();
        bus_if.sda_i = 1'b0; tick(2);
        bus_if.sda_i = 1'b1; tick(10);
        chk("glitch_sda_low_cycles", n_sda_low - b_sda_low, 0);
        chk("glitch_start_cnt", n_start - b_start, 0);

        // SCL fall reaches scl_o after exactly 2+FILT edges.
        bus_if.scl_i = 1'b0; tick(4);
        chk("latency_scl_before", bus_if.scl_o, 1);
        tick(1);
        chk("latency_scl_after", bus_if.scl_o, 0);
        bus_if.scl_i = 1'b1; tick(8);
        bus_if.enable_i = 1'b0; tick(2);
        bus_if.enable_i = 1'b1; tick(2);
        chk("latency_armed_o", bus_if.armed_o, 0);

        // Full clear: 9 clean pulses, then START with SCL high.
        snap();
        pulses(8); tick(6);
        chk("full_armed_after8", bus_if.armed_o, 0);
        pulses(1); tick(6);
        chk("full_armed_after9", bus_if.armed_o, 1);
        bus_if.sda_i = 1'b0; tick(12);
        chk("full_start_cnt", n_start - b_start, 1);
        chk("full_bus_reset_on", bus_if.bus_reset_o, 1);
        chk("full_armed_in_reset", bus_if.armed_o, 0);
        tick(70);
        chk("full_rst_cycles", n_rst - b_rst, RLEN);
        chk("full_rst_rises", n_rst_rise - b_rst_rise, 1);
        chk("full_rise_after_strobe", n_rise_ok - b_rise_ok, 1);
        chk("full_bus_reset_off", bus_if.bus_reset_o, 0);
        bus_if.sda_i = 1'b1; tick(10);

        // Short sequence: 8 pulses, SDA low across the next rise, then STOP.
        snap();
        pulses(8);
        bus_if.scl_i = 1'b0; tick(4);
        bus_if.sda_i = 1'b0; tick(4);
        bus_if.scl_i = 1'b1; tick(8);
        bus_if.sda_i = 1'b1; tick(10);
        chk("short_stop_cnt", n_stop - b_stop, 1);
        chk("short_armed_cycles", n_armed - b_armed, 0);
        chk("short_rst_cycles", n_rst - b_rst, 0);

        // Broken sequence: SDA low at the 5th rise restarts the count.
        snap();
        pulses(4);
        bus_if.scl_i = 1'b0; tick(2);
        bus_if.sda_i = 1'b0; tick(2);
        bus_if.scl_i = 1'b1; tick(4);
        bus_if.scl_i = 1'b0; tick(2);
        bus_if.sda_i = 1'b1; tick(2);
        bus_if.scl_i = 1'b1; tick(4);
        pulses(7); tick(6);
        chk("broken_armed_after8", bus_if.armed_o, 0);
        pulses(1); tick(6);
        chk("broken_armed_after9", bus_if.armed_o, 1);
        bus_if.sda_i = 1'b0; tick(82);
        chk("broken_rst_cycles", n_rst - b_rst, RLEN);
        chk("broken_rst_rises", n_rst_rise - b_rst_rise, 1);
        bus_if.sda_i = 1'b1; tick(10);

        // Bus events and enable low during the pulse must not disturb it.
        snap();
        pulses(9); tick(6);
        bus_if.sda_i = 1'b0; tick(12);
        bus_if.sda_i = 1'b1; tick(8);
        bus_if.sda_i = 1'b0; tick(8);
        bus_if.enable_i = 1'b0; tick(8);
        bus_if.enable_i = 1'b1; tick(50);
        chk("ignore_rst_cycles", n_rst - b_rst, RLEN);
        chk("ignore_rst_rises", n_rst_rise - b_rst_rise, 1);
        chk("ignore_start_cnt", n_start - b_start, 2);
        chk("ignore_stop_cnt", n_stop - b_stop, 1);
        chk("ignore_armed_after", bus_if.armed_o, 0);
        bus_if.sda_i = 1'b1; tick(10);

        // rst_ni asserted in cycle 20 of the pulse cuts it at the next edge.
        snap();
        pulses(9); tick(6);
        bus_if.sda_i = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int w = 0; w < 30 && !seen; w++) begin
                tick(1);
                if (bus_if.bus_reset_o === 1'b1) seen = 1'b1;
            end
            chk("trunc_pulse_started", {31'd0, seen}, 1);
        end
        tick(19);
        rst_n = 1'b0; tick(1);
        chk("trunc_bus_reset_off", bus_if.bus_reset_o, 0);
        tick(2);
        rst_n = 1'b1; tick(20);
        chk("trunc_rst_cycles", n_rst - b_rst, 20);
        chk("trunc_armed_o", bus_if.armed_o, 0);
        bus_if.sda_i = 1'b1; tick(10);

        // SCL and SDA moving together produce neither START nor STOP.
        snap();
        bus_if.scl_i = 1'b0; bus_if.sda_i = 1'b0; tick(10);
        bus_if.scl_i = 1'b1; bus_if.sda_i = 1'b1; tick(10);
        chk("coinc_start_cnt", n_start - b_start, 0);
        chk("coinc_stop_cnt", n_stop - b_stop, 0);
        chk("coinc_scl_o", bus_if.scl_o, 1);
        chk("coinc_sda_o", bus_if.sda_o, 1);
        bus_if.enable_i = 1'b0; tick(2);
        bus_if.enable_i = 1'b1; tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
